// File: rtl/sigmoid_share_arbiter.sv
// ----------------------------------------------------------------------------
// sigmoid_share_arbiter
//
// Two requesters share a single hard-sigmoid activation unit. A round-robin
// arbiter grants one requester at a time and keeps the grant locked for a
// whole vector, which ends with the beat that has reqN_last set. Each
// accepted sample is passed through a piecewise-linear sigmoid and shows up
// on the registered output stage one cycle after it is accepted. The source
// requester is tagged on out_id.
//
// Parameters
//   DATA_WIDTH : signed fixed-point sample width (Qm.n)
//   Q_FRAC     : number of fractional bits (1.0 = 1 << Q_FRAC)
//   SAT_LIMIT  : input magnitude at or beyond which the output saturates
//
// Ports
//   clk, rst                          : clock, asynchronous active-high reset
//   req0_valid/data/last, req0_ready  : requester 0 stream (last = end of vector)
//   req1_valid/data/last, req1_ready  : requester 1 stream
//   out_valid/data/id/last, out_ready : activation result stream, id = source
//   busy                              : arbiter holds a grant or output beat pending
//   stat_beats0/1, stat_stalls        : optional statistics counters
//
// Optional feature macro: SIGMOID_ARB_STATS_EN
//   defined   -> stat_beats0/1 count accepted beats per requester and
//                stat_stalls counts out_valid && !out_ready cycles, each
//                saturating at 16'hFFFF.
//   undefined -> stat ports are tied to zero and no counters are built.
// ----------------------------------------------------------------------------
module sigmoid_share_arbiter #(
   parameter int DATA_WIDTH = 16,
   parameter int Q_FRAC     = 8,
   parameter int SAT_LIMIT  = 1024
) (
   input  logic                         clk,
   input  logic                         rst,
   // requester 0
   input  logic                         req0_valid,
   input  logic signed [DATA_WIDTH-1:0] req0_data,
   input  logic                         req0_last,
   output logic                         req0_ready,
   // requester 1
   input  logic                         req1_valid,
   input  logic signed [DATA_WIDTH-1:0] req1_data,
   input  logic                         req1_last,
   output logic                         req1_ready,
   // result stream
   output logic                         out_valid,
   output logic signed [DATA_WIDTH-1:0] out_data,
   output logic                         out_id,
   output logic                         out_last,
   input  logic                         out_ready,
   // status
   output logic                         busy,
   output logic [15:0]                  stat_beats0,
   output logic [15:0]                  stat_beats1,
   output logic [15:0]                  stat_stalls
);

   // Two guard bits so that 0.5 + (x >>> 2) cannot overflow before clamping.
   localparam int EXT_W = DATA_WIDTH + 2;

   localparam logic signed [EXT_W-1:0] ONE_C     = EXT_W'(1 << Q_FRAC);
   localparam logic signed [EXT_W-1:0] HALF_C    = EXT_W'(1 << (Q_FRAC - 1));
   localparam logic signed [EXT_W-1:0] ZERO_C    = EXT_W'(0);
   localparam logic signed [EXT_W-1:0] LIM_C     = EXT_W'(SAT_LIMIT);
   localparam logic signed [EXT_W-1:0] NEG_LIM_C = -LIM_C;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT0 = 2'd1,
      ST_GRANT1 = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // Hard sigmoid: saturate outside +/-SAT_LIMIT, otherwise 0.5 + x/4
   // clamped into [0, 1.0]. The arithmetic shift gives floor(x/4).
   // ------------------------------------------------------------------------
   function automatic logic [DATA_WIDTH-1:0] sigmoid_f(
      input logic signed [DATA_WIDTH-1:0] x
   );
      logic signed [EXT_W-1:0] x_ext;
      logic signed [EXT_W-1:0] lin;
      logic signed [EXT_W-1:0] res;
      x_ext = {{2{x[DATA_WIDTH-1]}}, x};
      lin   = HALF_C + (x_ext >>> 2);
      if (x_ext >= LIM_C) begin
         res = ONE_C;
      end else if (x_ext <= NEG_LIM_C) begin
         res = ZERO_C;
      end else if (lin < ZERO_C) begin
         res = ZERO_C;
      end else if (lin > ONE_C) begin
         res = ONE_C;
      end else begin
         res = lin;
      end
      return res[DATA_WIDTH-1:0];
   endfunction

   // Saturating 16-bit increment used by the statistics counters.
   function automatic logic [15:0] sat_inc16(
      input logic [15:0] cnt,
      input logic        en
   );
      logic [15:0] nxt;
      if (en && (cnt != 16'hFFFF)) begin
         nxt = cnt + 16'd1;
      end else begin
         nxt = cnt;
      end
      return nxt;
   endfunction

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t                  state_q,     state_d;
   logic                    favor1_q,    favor1_d;   // 1: req1 wins a tie
   logic                    out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0]   out_data_q,  out_data_d;
   logic                    out_id_q,    out_id_d;
   logic                    out_last_q,  out_last_d;

   logic                    can_load;   // output stage can take a beat this cycle
   logic                    accept0;
   logic                    accept1;
   logic                    accept_any;
   logic signed [DATA_WIDTH-1:0] sel_data;
   logic                    sel_last;

   // The output register may be refilled when empty or drained this cycle.
   assign can_load   = !out_valid_q || out_ready;
   assign accept0    = req0_valid && req0_ready;
   assign accept1    = req1_valid && req1_ready;
   assign accept_any = accept0 || accept1;

   // State register for the arbitration FSM and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         favor1_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         favor1_q <= favor1_d;
      end
   end

   // Next-state logic: arbitrate only from IDLE, release only on an accepted last beat.
   always_comb begin
      state_d  = state_q;
      favor1_d = favor1_q;
      case (state_q)
         ST_IDLE: begin
            // req0 wins if it is the only one asking or if it is its turn.
            if (req0_valid && (!req1_valid || !favor1_q)) begin
               state_d  = ST_GRANT0;
               favor1_d = 1'b1;
            end else if (req1_valid) begin
               state_d  = ST_GRANT1;
               favor1_d = 1'b0;
            end else begin
               state_d  = ST_IDLE;
               favor1_d = favor1_q;
            end
         end
         ST_GRANT0: begin
            if (accept0 && req0_last) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_GRANT0;
            end
         end
         ST_GRANT1: begin
            if (accept1 && req1_last) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_GRANT1;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            favor1_d = 1'b0;
         end
      endcase
   end

   // FSM outputs: only the granted requester sees ready, and only when the
   // output stage can take its beat.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      sel_data   = req0_data;
      sel_last   = req0_last;
      case (state_q)
         ST_GRANT0: begin
            req0_ready = can_load;
            req1_ready = 1'b0;
            sel_data   = req0_data;
            sel_last   = req0_last;
         end
         ST_GRANT1: begin
            req0_ready = 1'b0;
            req1_ready = can_load;
            sel_data   = req1_data;
            sel_last   = req1_last;
         end
         ST_IDLE: begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
         end
         default: begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
         end
      endcase
   end

   // Output stage next value: load on accept, clear on drain, else hold.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;
      out_last_d  = out_last_q;
      if (accept_any) begin
         out_valid_d = 1'b1;
         out_data_d  = sigmoid_f(sel_data);
         out_id_d    = accept1;
         out_last_d  = sel_last;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Output stage register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= {DATA_WIDTH{1'b0}};
         out_id_q    <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q != ST_IDLE) || out_valid_q;

`ifdef SIGMOID_ARB_STATS_EN
   logic [15:0] beats0_q, beats0_d;
   logic [15:0] beats1_q, beats1_d;
   logic [15:0] stalls_q, stalls_d;

   // Statistics next values, each saturating at all-ones.
   always_comb begin
      beats0_d = sat_inc16(beats0_q, accept0);
      beats1_d = sat_inc16(beats1_q, accept1);
      stalls_d = sat_inc16(stalls_q, out_valid_q && !out_ready);
   end

   // Statistics registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beats0_q <= 16'd0;
         beats1_q <= 16'd0;
         stalls_q <= 16'd0;
      end else begin
         beats0_q <= beats0_d;
         beats1_q <= beats1_d;
         stalls_q <= stalls_d;
      end
   end

   assign stat_beats0 = beats0_q;
   assign stat_beats1 = beats1_q;
   assign stat_stalls = stalls_q;
`else
   assign stat_beats0 = 16'd0;
   assign stat_beats1 = 16'd0;
   assign stat_stalls = 16'd0;
`endif

endmodule

// File: tb/tb_sigmoid_share_arbiter.sv
// ----------------------------------------------------------------------------
// Testbench for sigmoid_share_arbiter. A transaction-level model tracks which
// requester owns the shared unit and which beats must come out, pushes
// expected results into a scoreboard queue, and an independent monitor
// compares every presented output beat, the ready lines, busy and the
// statistics counters against it.
// ----------------------------------------------------------------------------
module tb_sigmoid_share_arbiter;
   localparam int DW = 16;
   localparam int QF = 8;
   localparam int SL = 1024;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 req0_valid = 1'b0, req0_last = 1'b0;
   logic signed [DW-1:0] req0_data  = '0;
   logic                 req0_ready;
   logic                 req1_valid = 1'b0, req1_last = 1'b0;
   logic signed [DW-1:0] req1_data  = '0;
   logic                 req1_ready;
   logic                 out_valid, out_id, out_last;
   logic [DW-1:0]        out_data;
   logic                 out_ready = 1'b1;
   logic                 busy;
   logic [15:0]          stat_beats0, stat_beats1, stat_stalls;

   always #5 clk = ~clk;

   sigmoid_share_arbiter #(.DATA_WIDTH(DW), .Q_FRAC(QF), .SAT_LIMIT(SL)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
      .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_last(out_last),
      .out_ready(out_ready), .busy(busy),
      .stat_beats0(stat_beats0), .stat_beats1(stat_beats1), .stat_stalls(stat_stalls)
   );

   typedef struct { logic [15:0] d; logic l; } src_t;
   typedef struct { logic id; logic [15:0] d; logic l; } exp_t;

   src_t srcq0[$], srcq1[$];   // beats still to be offered per requester
   exp_t sbq[$];               // expected output beats, oldest first
   exp_t logq[$];              // beats the monitor has seen drained

   int n_cmp  = 0;
   int n_fail = 0;

   // transaction model state
   int m_owner  = -1;          // -1 none, else requester holding the grant
   int m_prefer = 0;           // requester that wins a tie
   bit m_ov     = 1'b0;        // an output beat is pending
   int m_beats0 = 0, m_beats1 = 0, m_stalls = 0;

   int or_mode  = 0;           // 0 out_ready=1, 1 random, 2 left to main
   bit gap_en   = 1'b0;        // randomly drop valid
   int acc1_cnt = 0;

   // Sigmoid from its definition in plain integer arithmetic.
   function automatic int sig_ref(input int x);
      int v;
      if (x >= SL) return 1 << QF;
      if (x <= -SL) return 0;
      v = (1 << (QF - 1)) + (x >>> 2);
      if (v < 0) return 0;
      if (v > (1 << QF)) return 1 << QF;
      return v;
   endfunction

   function automatic int sat16(input int c);
      return (c < 65535) ? c + 1 : c;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: decides accepts and grants from the arbitration rules.
   initial forever begin
      bit can, a0, a1;
      @(posedge clk or posedge rst);
      if (rst) begin
         m_owner = -1; m_prefer = 0; m_ov = 1'b0;
         m_beats0 = 0; m_beats1 = 0; m_stalls = 0;
         sbq.delete();
      end else begin
         can = !m_ov || out_ready;
         a0  = (m_owner == 0) && req0_valid && can;
         a1  = (m_owner == 1) && req1_valid && can;
`ifdef SIGMOID_ARB_STATS_EN
         if (m_ov && !out_ready) m_stalls = sat16(m_stalls);
         if (a0) m_beats0 = sat16(m_beats0);
         if (a1) m_beats1 = sat16(m_beats1);
`endif
         if (a0) sbq.push_back('{1'b0, 16'(sig_ref(int'(req0_data))), req0_last});
         if (a1) sbq.push_back('{1'b1, 16'(sig_ref(int'(req1_data))), req1_last});
         if (a0 || a1) m_ov = 1'b1;
         else if (out_ready) m_ov = 1'b0;
         if (m_owner < 0) begin
            if (req0_valid && req1_valid) m_owner = m_prefer;
            else if (req0_valid) m_owner = 0;
            else if (req1_valid) m_owner = 1;
            if (m_owner >= 0) m_prefer = 1 - m_owner;
         end else if ((a0 && req0_last) || (a1 && req1_last)) begin
            m_owner = -1;
         end
      end
   end

   // Monitor: compares DUT outputs against the model each cycle mid-period.
   initial forever begin
      exp_t e;
      @(negedge clk);
      check("out_valid", out_valid, m_ov);
      if (m_ov) begin
         if (sbq.size() == 0) begin
            check("scoreboard_empty", 1, 0);
         end else begin
            e = sbq[0];
            check("out_data", out_data, e.d);
            check("out_id", out_id, e.id);
            check("out_last", out_last, e.l);
            if (out_ready) begin
               logq.push_back(e);
               void'(sbq.pop_front());
            end
         end
      end
      check("req0_ready", req0_ready, (m_owner == 0) && (!m_ov || out_ready));
      check("req1_ready", req1_ready, (m_owner == 1) && (!m_ov || out_ready));
      check("busy", busy, (m_owner >= 0) || m_ov);
      check("stat_beats0", stat_beats0, m_beats0);
      check("stat_beats1", stat_beats1, m_beats1);
      check("stat_stalls", stat_stalls, m_stalls);
   end

   // Driver: offers queued beats, advances on handshake, drives out_ready.
   initial forever begin
      bit a0, a1;
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      if (a1) acc1_cnt++;
      @(posedge clk);
      #1;
      if (a0 && srcq0.size() > 0) void'(srcq0.pop_front());
      if (a1 && srcq1.size() > 0) void'(srcq1.pop_front());
      if (rst) begin
         req0_valid = 1'b0;
         req1_valid = 1'b0;
      end else begin
         req0_valid = (srcq0.size() > 0) && (!gap_en || $urandom_range(3) != 0);
         req1_valid = (srcq1.size() > 0) && (!gap_en || $urandom_range(3) != 0);
         if (srcq0.size() > 0) begin req0_data = srcq0[0].d; req0_last = srcq0[0].l; end
         if (srcq1.size() > 0) begin req1_data = srcq1[0].d; req1_last = srcq1[0].l; end
      end
      case (or_mode)
         0: out_ready = 1'b1;
         1: out_ready = ($urandom_range(3) != 0);
         default: ;
      endcase
   end

   function automatic logic [15:0] rand_sample();
      if ($urandom_range(1) == 1) return 16'($urandom);
      return 16'(int'($urandom_range(2200)) - 1100);
   endfunction

   task automatic push_vec(input int who, input int len);
      src_t s;
      for (int i = 0; i < len; i++) begin
         s.d = rand_sample();
         s.l = (i == len - 1);
         if (who == 0) srcq0.push_back(s); else srcq1.push_back(s);
      end
   endtask

   task automatic wait_drain(input int budget);
      int cyc = 0;
      while ((srcq0.size() > 0 || srcq1.size() > 0 || sbq.size() > 0 || m_ov || m_owner >= 0)
             && cyc < budget) begin
         @(posedge clk);
         cyc++;
      end
      if (cyc >= budget) check("drain_timeout", cyc, budget - 1);
      @(posedge clk);
      #2;
   endtask

   initial begin
      int cyc;
      logic [15:0] s0;
      int exp23[4];
      logic [15:0] dir23[4];
      logic [15:0] bnd[8];
      exp23 = '{128, 192, 256, 0};
      dir23 = '{16'h0000, 16'h0100, 16'h0400, 16'hFD00};
      bnd   = '{16'd1024, 16'd1023, 16'd1025, 16'hFC00, 16'hFC01, 16'hFBFF, 16'h7FFF, 16'h8000};

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      check("reset_out_data", out_data, 0);
      check("reset_out_id_last", {out_id, out_last}, 0);
      check("reset_out_valid", out_valid, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #2;

      // single beats with known results
      logq.delete();
      for (int i = 0; i < 4; i++) srcq0.push_back('{dir23[i], 1'b1});
      wait_drain(100);
      check("single_count", logq.size(), 4);
      for (int i = 0; i < 4 && i < logq.size(); i++) begin
         check("single_data", logq[i].d, exp23[i]);
         check("single_id", logq[i].id, 0);
      end

      // both requesters waiting when reset releases
      @(posedge clk); #2 rst = 1'b1;
      push_vec(0, 3);
      push_vec(1, 3);
      @(posedge clk); #2 rst = 1'b0;
      logq.delete();
      wait_drain(100);
      check("rr_count", logq.size(), 6);
      for (int i = 0; i < 6 && i < logq.size(); i++) begin
         check("rr_id", logq[i].id, (i < 3) ? 0 : 1);
         check("rr_last", logq[i].l, (i == 2 || i == 5) ? 1 : 0);
      end

      // continuous contention alternates per vector
      logq.delete();
      for (int v = 0; v < 3; v++) begin push_vec(0, 2); push_vec(1, 2); end
      wait_drain(200);
      check("alt_count", logq.size(), 12);
      for (int i = 0; i < 12 && i < logq.size(); i++) check("alt_id", logq[i].id, (i / 2) % 2);

      // output held off for four cycles
      or_mode = 2;
      out_ready = 1'b0;
      push_vec(0, 1);
      cyc = 0;
      while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
      check("stall_valid_seen", out_valid, 1);
      s0 = stat_stalls;
      repeat (4) @(negedge clk);
`ifdef SIGMOID_ARB_STATS_EN
      check("stall_delta", 16'(stat_stalls - s0), 4);
`else
      check("stall_delta", 16'(stat_stalls - s0), 0);
`endif
      @(posedge clk); #2;
      out_ready = 1'b1;
      or_mode = 0;
      wait_drain(50);

      // reset in the middle of a req1 vector
      acc1_cnt = 0;
      push_vec(1, 4);
      cyc = 0;
      while (acc1_cnt < 2 && cyc < 50) begin @(posedge clk); cyc++; end
      check("mid_vec_accepts", acc1_cnt, 2);
      #2 rst = 1'b1;
      #1;
      check("rst_async_out_valid", out_valid, 0);
      check("rst_async_busy", busy, 0);
      srcq0.delete();
      srcq1.delete();
      push_vec(0, 1);
      push_vec(1, 1);
      @(posedge clk); #2 rst = 1'b0;
      logq.delete();
      wait_drain(100);
      check("post_rst_count", logq.size(), 2);
      if (logq.size() > 0) check("post_rst_first_id", logq[0].id, 0);

      // randomized traffic with boundary samples mixed in
      for (int i = 0; i < 8; i++) srcq0.push_back('{bnd[i], i == 7});
      gap_en = 1'b1;
      or_mode = 1;
      for (int c = 0; c < 3000; c++) begin
         if (srcq0.size() < 3 && $urandom_range(2) == 0) push_vec(0, $urandom_range(4, 1));
         if (srcq1.size() < 3 && $urandom_range(2) == 0) push_vec(1, $urandom_range(4, 1));
         @(posedge clk);
      end
      gap_en = 1'b0;
      or_mode = 0;
      wait_drain(500);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/sigmoid_share_arbiter.md
SIGMOID_SHARE_ARBITER -- requirements
Module: sigmoid_share_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, signed Qm.n sample width.
REQ-002 SHALL have parameter Q_FRAC, default 8, fractional bits.
REQ-003 SHALL have parameter SAT_LIMIT, default 1024 (4.0 in Q8.8), input saturation magnitude.
REQ-004 SHALL have one clock and asynchronous active-high reset: clk  in  1  clock; rst  in  1  async active-high reset.
REQ-005 SHALL have ports req0_valid in 1, req0_data in DATA_WIDTH signed, req0_last in 1 (final element of vector), req0_ready out 1.
REQ-006 SHALL have ports req1_valid in 1, req1_data in DATA_WIDTH signed, req1_last in 1, req1_ready out 1.
REQ-007 SHALL have ports out_valid out 1, out_data out DATA_WIDTH signed, out_id out 1 (source requester), out_last out 1, out_ready in 1.
REQ-008 SHALL have port busy out 1, high whenever the FSM is not IDLE or out_valid is high.
REQ-009 SHALL have ports stat_beats0 out 16, stat_beats1 out 16, stat_stalls out 16 (see Configuration).

Function
REQ-010 FSM states SHALL be IDLE, GRANT0, GRANT1.
REQ-011 In IDLE, one valid requester SHALL be granted next cycle; if both are valid, the one not served last SHALL be granted; after reset req0 is favoured.
REQ-012 Grant SHALL stay locked until a beat with reqN_last=1 is accepted; the FSM SHALL then return to IDLE (one-cycle arbitration bubble).
REQ-013 reqN_ready SHALL be high only in GRANTN and when (!out_valid || out_ready); never in IDLE; non-granted ready SHALL be 0.
REQ-014 Accept = reqN_valid && reqN_ready; an accepted beat SHALL appear on out_* exactly one cycle later (registered, latency 1).
REQ-015 Activation SHALL be: x >= SAT_LIMIT -> 1.0; x <= -SAT_LIMIT -> 0; else clamp(0.5 + (x >>> 2), 0, 1.0), computed in DATA_WIDTH+2 bits, 1.0 = 1<<Q_FRAC, 0.5 = 1<<(Q_FRAC-1).
REQ-016 out_valid high with out_ready low SHALL hold out_data/out_id/out_last stable and deassert reqN_ready.
REQ-017 out_valid SHALL clear on out_ready when no new beat is accepted the same cycle; simultaneous drain and accept SHALL reload without a bubble.
REQ-018 The non-granted requester's valid/data SHALL be ignored entirely; a granted requester dropping valid mid-vector SHALL keep the grant.

Reset
REQ-019 rst asserted SHALL asynchronously force FSM=IDLE, round-robin pointer to favour req0, out_valid=0, out_data=0, out_id=0, out_last=0, all stat counters=0.
REQ-020 Reset mid-vector SHALL discard the partial vector and any held output beat; no beat is emitted after release until a new grant.

Configuration
REQ-021 Macro SIGMOID_ARB_STATS_EN defined: stat_beats0/1 SHALL count accepted beats per requester, stat_stalls SHALL count cycles with out_valid && !out_ready; all saturate at 0xFFFF.
REQ-022 Macro SIGMOID_ARB_STATS_EN undefined: stat ports SHALL exist but be constant 0 and no counter logic SHALL be synthesised.

Verification
REQ-023 Single beats req0_data 0x0000, 0x0100, 0x0400, 0xFD00 (last=1 each, out_ready=1) -> out_data 0x0080, 0x00C0, 0x0100, 0x0000, each one cycle after accept, out_id=0.
REQ-024 Both requesters valid at reset release, 3-beat vectors each -> req0 vector fully first, one IDLE bubble, then req1; out_id 0,0,0 then 1,1,1; out_last on 3rd and 6th beats.
REQ-025 Back-to-back contention, req0 and req1 continuously valid -> grants alternate 0,1,0,1 per vector.
REQ-026 out_ready held low 4 cycles with out_valid=1 -> out_data stable, reqN_ready=0, stat_stalls increments by 4 (macro on) or stays 0 (macro off).
REQ-027 rst pulsed after beat 2 of a 4-beat req1 vector -> out_valid=0 immediately, FSM IDLE, next grant goes to req0 if both valid.
